// File: rtl/apple1_bus_fabric.sv
// CPU bus fabric for the Apple-1 6502: table-driven slot decode, read-data mux and
// stall control with per-slot wait states, ack-terminated slots, timeout and sticky bus error.
module apple1_bus_fabric #(
  parameter int                        NSLOT     = 8,
  parameter logic [16*NSLOT-1:0]       SLOT_BASE = '0,
  parameter logic [16*NSLOT-1:0]       SLOT_MASK = '0,
  parameter int                        WAIT_W    = 4,
  parameter logic [WAIT_W*NSLOT-1:0]   SLOT_WAIT = '0,
  parameter logic [NSLOT-1:0]          SLOT_ACK  = '0,
  parameter int                        TIMEOUT   = 255
) (
  input  logic               clk14,
  input  logic               rst,
  input  logic               cpu_clken,
  input  logic [15:0]        ab,
  input  logic               we,
  input  logic [7:0]         dbo,
  output logic [7:0]         dbi,
  output logic               cpu_ready,
  output logic [NSLOT-1:0]   slot_cs,
  output logic [NSLOT-1:0]   slot_we,
  output logic [7:0]         slot_din,
  input  logic [NSLOT*8-1:0] slot_dout,
  input  logic [NSLOT-1:0]   slot_ack,
  output logic               bus_err,
  input  logic               bus_err_clr
);

  if (NSLOT < 1 || NSLOT > 16) begin : g_bad_nslot
    $error("apple1_bus_fabric: NSLOT must be 1..16");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("apple1_bus_fabric: TIMEOUT must be 1..65535");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_r, state_n;
  logic [3:0]          sel_r, sel_n;
  logic [WAIT_W-1:0]   wcnt_r, wcnt_n;
  logic [15:0]         tcnt_r, tcnt_n;
  logic [7:0]          rdata_r, rdata_n;
  logic                bus_err_r;
  logic                err_set_s;

  logic                hit_any_s;
  logic [3:0]          hit_idx_s;
  logic [WAIT_W-1:0]   hit_wait_s;
  logic                hit_ack_s;
  logic [7:0]          hit_dout_s;
  logic                sel_ack_s;
  logic                sel_acked_s;
  logic [7:0]          sel_dout_s;

  logic [3:0]          cs_idx_s;
  logic                cs_valid_s;
  logic                ready_s;
  logic [7:0]          dbi_s;
  logic [NSLOT-1:0]    cs_s;
  logic [NSLOT-1:0]    we_s;

  function automatic logic [NSLOT-1:0] onehot(input logic [3:0] idx);
    return NSLOT'(1'b1) << idx;
  endfunction

  // Address decode; scanning downward lets the lowest matching index win
  always_comb begin
    hit_any_s = 1'b0;
    hit_idx_s = 4'd0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (((ab ^ SLOT_BASE[16*i +: 16]) & SLOT_MASK[16*i +: 16]) == 16'h0000) begin
        hit_any_s = 1'b1;
        hit_idx_s = 4'(i);
      end else begin
        hit_any_s = hit_any_s;
      end
    end
  end

  // Per-slot attributes of the decoded slot and of the latched slot
  always_comb begin
    hit_wait_s  = WAIT_W'(SLOT_WAIT >> (WAIT_W * int'(hit_idx_s)));
    hit_ack_s   = 1'(SLOT_ACK >> hit_idx_s);
    hit_dout_s  = 8'(slot_dout >> (8 * int'(hit_idx_s)));
    sel_ack_s   = 1'(SLOT_ACK >> sel_r);
    sel_acked_s = 1'(slot_ack >> sel_r);
    sel_dout_s  = 8'(slot_dout >> (8 * int'(sel_r)));
  end

  // Next-state and bus outputs
  always_comb begin
    state_n    = state_r;
    sel_n      = sel_r;
    wcnt_n     = wcnt_r;
    tcnt_n     = tcnt_r;
    rdata_n    = rdata_r;
    err_set_s  = 1'b0;
    cs_idx_s   = sel_r;
    cs_valid_s = 1'b1;
    ready_s    = 1'b0;
    dbi_s      = rdata_r;
    case (state_r)
      S_IDLE: begin
        cs_idx_s   = hit_idx_s;
        cs_valid_s = hit_any_s;
        ready_s    = ~hit_any_s | ((hit_wait_s == {WAIT_W{1'b0}}) & ~hit_ack_s);
        dbi_s      = hit_any_s ? hit_dout_s : 8'hFF;
        if (cpu_clken && !ready_s) begin
          state_n = S_WAIT;
          sel_n   = hit_idx_s;
          wcnt_n  = hit_wait_s;
          tcnt_n  = 16'd0;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!sel_ack_s) begin
          wcnt_n = (wcnt_r == {WAIT_W{1'b0}}) ? wcnt_r : wcnt_r - WAIT_W'(1);
          if (wcnt_r <= WAIT_W'(1)) begin
            rdata_n = sel_dout_s;
            state_n = S_DONE;
          end else begin
            state_n = S_WAIT;
          end
        end else begin
          // Ack is tested before the timeout so a last-cycle ack is not an error
          tcnt_n = (tcnt_r == 16'(TIMEOUT - 1)) ? tcnt_r : tcnt_r + 16'd1;
          if (sel_acked_s) begin
            rdata_n = sel_dout_s;
            state_n = S_DONE;
          end else if (tcnt_r == 16'(TIMEOUT - 1)) begin
            rdata_n   = 8'hFF;
            err_set_s = 1'b1;
            state_n   = S_DONE;
          end else begin
            state_n = S_WAIT;
          end
        end
      end
      S_DONE: begin
        ready_s = 1'b1;
        if (cpu_clken) begin
          state_n = S_IDLE;
        end else begin
          state_n = S_DONE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
    cs_s = cs_valid_s ? onehot(cs_idx_s) : {NSLOT{1'b0}};
    we_s = (we & ready_s & cpu_clken & ~rst) ? cs_s : {NSLOT{1'b0}};
  end

  // FSM state, counters and captured read data
  always_ff @(posedge clk14 or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
      sel_r   <= 4'd0;
      wcnt_r  <= {WAIT_W{1'b0}};
      tcnt_r  <= 16'd0;
      rdata_r <= 8'hFF;
    end else begin
      state_r <= state_n;
      sel_r   <= sel_n;
      wcnt_r  <= wcnt_n;
      tcnt_r  <= tcnt_n;
      rdata_r <= rdata_n;
    end
  end

  // Sticky bus error; a timeout in the same cycle as a clear keeps the flag set
  always_ff @(posedge clk14 or posedge rst) begin
    if (rst) begin
      bus_err_r <= 1'b0;
    end else if (err_set_s) begin
      bus_err_r <= 1'b1;
    end else if (bus_err_clr) begin
      bus_err_r <= 1'b0;
    end else begin
      bus_err_r <= bus_err_r;
    end
  end

  assign dbi       = dbi_s;
  assign cpu_ready = ready_s;
  assign slot_cs   = cs_s;
  assign slot_we   = we_s;
  assign slot_din  = dbo;
  assign bus_err   = bus_err_r;

endmodule

// File: tb/tb_apple1_bus_fabric.sv
// Directed bench for apple1_bus_fabric: decode, wait-state stall, ack/timeout,
// sticky error, unmapped/overlap decode and reset during an access.
module tb_apple1_bus_fabric;

  localparam int NSLOT  = 8;
  localparam int WAIT_W = 4;

  logic               clk14 = 1'b0;
  logic               rst;
  logic               cpu_clken;
  logic [15:0]        ab;
  logic               we;
  logic [7:0]         dbo;
  logic [7:0]         dbi;
  logic               cpu_ready;
  logic [NSLOT-1:0]   slot_cs;
  logic [NSLOT-1:0]   slot_we;
  logic [7:0]         slot_din;
  logic [NSLOT*8-1:0] slot_dout;
  logic [NSLOT-1:0]   slot_ack;
  logic               bus_err;
  logic               bus_err_clr;

  int n_vec = 0;
  int n_fail = 0;
  int we_pulses = 0;
  int stall;
  int we_seen;

  // Slot map: 0 = 0000-1FFF, 1 = 2000-2FFF, 2 = D010-D01F (3 waits),
  // 3 = 2000-27FF (shadowed by 1), 4 = C0xx ack slot, 5..7 = F0xx..F2xx
  apple1_bus_fabric #(
    .NSLOT     (NSLOT),
    .SLOT_BASE ({16'hF200, 16'hF100, 16'hF000, 16'hC000, 16'h2000, 16'hD010, 16'h2000, 16'h0000}),
    .SLOT_MASK ({16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00, 16'hF800, 16'hFFF0, 16'hF000, 16'hE000}),
    .WAIT_W    (WAIT_W),
    .SLOT_WAIT (32'h0000_0300),
    .SLOT_ACK  (8'b0001_0000),
    .TIMEOUT   (16)
  ) dut (
    .clk14       (clk14),
    .rst         (rst),
    .cpu_clken   (cpu_clken),
    .ab          (ab),
    .we          (we),
    .dbo         (dbo),
    .dbi         (dbi),
    .cpu_ready   (cpu_ready),
    .slot_cs     (slot_cs),
    .slot_we     (slot_we),
    .slot_din    (slot_din),
    .slot_dout   (slot_dout),
    .slot_ack    (slot_ack),
    .bus_err     (bus_err),
    .bus_err_clr (bus_err_clr)
  );

  always #5 clk14 = ~clk14;

  always @(posedge clk14) we_pulses <= we_pulses + $countones(slot_we);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk14);
    #1;
  endtask

  task automatic set_dout(input int idx, input logic [7:0] v);
    slot_dout[8*idx +: 8] = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cpu_clken = 1'b0; ab = 16'h8000; we = 1'b0; dbo = 8'h00;
    slot_dout = '0; slot_ack = '0; bus_err_clr = 1'b0;
    tick(); tick();
    rst = 1'b0; #1;
    check_eq("rst_ready", 32'(cpu_ready), 32'd1);
    check_eq("rst_dbi",   32'(dbi),       32'h0000_00FF);
    check_eq("rst_cs",    32'(slot_cs),   32'h0000_0000);
    check_eq("rst_we",    32'(slot_we),   32'h0000_0000);
    check_eq("rst_err",   32'(bus_err),   32'd0);

    // zero-wait read and write on slot 0
    tick();
    ab = 16'h1234; set_dout(0, 8'h5A); cpu_clken = 1'b1; #1;
    check_eq("t1_dbi",   32'(dbi),       32'h0000_005A);
    check_eq("t1_ready", 32'(cpu_ready), 32'd1);
    check_eq("t1_cs",    32'(slot_cs),   32'h0000_0001);
    check_eq("t1_we",    32'(slot_we),   32'h0000_0000);
    tick(); cpu_clken = 1'b0; #1;
    check_eq("t1_nostall", 32'(cpu_ready), 32'd1);
    we = 1'b1; dbo = 8'h77; cpu_clken = 1'b1; #1;
    check_eq("t1_wr_we",  32'(slot_we),  32'h0000_0001);
    check_eq("t1_wr_din", 32'(slot_din), 32'h0000_0077);
    tick(); cpu_clken = 1'b0; we = 1'b0;

    // three wait states on slot 2
    ab = 16'hD012; we = 1'b1; dbo = 8'hA5; cpu_clken = 1'b1; #1;
    check_eq("t2_req_ready", 32'(cpu_ready), 32'd0);
    check_eq("t2_req_cs",    32'(slot_cs),   32'h0000_0004);
    check_eq("t2_req_we",    32'(slot_we),   32'h0000_0000);
    tick(); cpu_clken = 1'b0; ab = 16'h1234; #1;
    check_eq("t2_wait_cs", 32'(slot_cs), 32'h0000_0004);
    stall = 0; we_seen = 0;
    for (int k = 0; k < 20 && cpu_ready == 1'b0; k++) begin
      stall++;
      if (slot_we != '0) we_seen = 1;
      tick(); #1;
    end
    check_eq("t2_stall",      32'(stall),     32'd3);
    check_eq("t2_wait_we",    32'(we_seen),   32'd0);
    check_eq("t2_done_ready", 32'(cpu_ready), 32'd1);
    check_eq("t2_done_we0",   32'(slot_we),   32'h0000_0000);
    cpu_clken = 1'b1; #1;
    check_eq("t2_strobe", 32'(slot_we),  32'h0000_0004);
    check_eq("t2_din",    32'(slot_din), 32'h0000_00A5);
    tick(); cpu_clken = 1'b0; we = 1'b0; #1;
    check_eq("t2_after_we", 32'(slot_we), 32'h0000_0000);

    // ack slot acknowledged after 5 wait cycles
    ab = 16'hC000; set_dout(4, 8'h3C); cpu_clken = 1'b1; #1;
    check_eq("t3_req_ready", 32'(cpu_ready), 32'd0);
    tick(); cpu_clken = 1'b0;
    repeat (4) tick();
    slot_ack = 8'h10; #1;
    check_eq("t3_pre_ack", 32'(cpu_ready), 32'd0);
    tick(); slot_ack = 8'h00; #1;
    check_eq("t3_ready", 32'(cpu_ready), 32'd1);
    check_eq("t3_dbi",   32'(dbi),       32'h0000_003C);
    check_eq("t3_err",   32'(bus_err),   32'd0);
    cpu_clken = 1'b1; tick(); cpu_clken = 1'b0;

    // ack arrives on the last cycle before timeout
    set_dout(4, 8'hC3); cpu_clken = 1'b1; #1;
    tick(); cpu_clken = 1'b0;
    repeat (15) tick();
    slot_ack = 8'h10; #1;
    check_eq("t3b_pre_ack", 32'(cpu_ready), 32'd0);
    tick(); slot_ack = 8'h00; #1;
    check_eq("t3b_ready", 32'(cpu_ready), 32'd1);
    check_eq("t3b_dbi",   32'(dbi),       32'h0000_00C3);
    check_eq("t3b_err",   32'(bus_err),   32'd0);
    cpu_clken = 1'b1; tick(); cpu_clken = 1'b0;

    // no ack: timeout after 16 cycles
    cpu_clken = 1'b1; #1;
    tick(); cpu_clken = 1'b0; #1;
    stall = 0;
    for (int k = 0; k < 40 && cpu_ready == 1'b0; k++) begin
      stall++;
      tick(); #1;
    end
    check_eq("t4_stall", 32'(stall),   32'd16);
    check_eq("t4_dbi",   32'(dbi),     32'h0000_00FF);
    check_eq("t4_err",   32'(bus_err), 32'd1);
    cpu_clken = 1'b1; tick(); cpu_clken = 1'b0; ab = 16'h8000;
    tick(); tick(); #1;
    check_eq("t4_sticky", 32'(bus_err), 32'd1);
    bus_err_clr = 1'b1; #1;
    check_eq("t4_clr_sync", 32'(bus_err), 32'd1);
    tick(); bus_err_clr = 1'b0; #1;
    check_eq("t4_cleared", 32'(bus_err), 32'd0);

    // timeout while clear is held: set wins
    ab = 16'hC000; bus_err_clr = 1'b1; cpu_clken = 1'b1; #1;
    tick(); cpu_clken = 1'b0;
    repeat (16) tick();
    #1;
    check_eq("t4_prio_ready", 32'(cpu_ready), 32'd1);
    check_eq("t4_prio_err",   32'(bus_err),   32'd1);
    bus_err_clr = 1'b0; cpu_clken = 1'b1; tick(); cpu_clken = 1'b0;
    bus_err_clr = 1'b1; tick(); bus_err_clr = 1'b0;

    // unmapped access and overlapping decode
    ab = 16'h8000; we = 1'b0; cpu_clken = 1'b1; #1;
    check_eq("t5_dbi",   32'(dbi),       32'h0000_00FF);
    check_eq("t5_ready", 32'(cpu_ready), 32'd1);
    check_eq("t5_cs",    32'(slot_cs),   32'h0000_0000);
    we = 1'b1; dbo = 8'h99; #1;
    check_eq("t5_we", 32'(slot_we), 32'h0000_0000);
    tick(); cpu_clken = 1'b0; we = 1'b0; ab = 16'h2100; #1;
    check_eq("t5_overlap_cs", 32'(slot_cs), 32'h0000_0002);

    // reset in the middle of a wait-state write
    ab = 16'hD012; we = 1'b1; dbo = 8'h11; cpu_clken = 1'b1; #1;
    tick(); cpu_clken = 1'b0;
    tick();
    ab = 16'h1234; rst = 1'b1; #1;
    check_eq("t6_rst_ready", 32'(cpu_ready), 32'd1);
    check_eq("t6_rst_we",    32'(slot_we),   32'h0000_0000);
    tick(); rst = 1'b0; we = 1'b0; cpu_clken = 1'b1; #1;
    check_eq("t6_dbi",   32'(dbi),       32'h0000_005A);
    check_eq("t6_ready", 32'(cpu_ready), 32'd1);
    check_eq("t6_cs",    32'(slot_cs),   32'h0000_0001);
    tick(); cpu_clken = 1'b0; tick(); #1;
    check_eq("we_pulse_total", 32'(we_pulses), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
